// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign correction on the last step.
module muldiv_unit #(
  parameter int BIT_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [2:0]           Op,
  input  logic [BIT_COUNT-1:0] OpA,
  input  logic [BIT_COUNT-1:0] OpB,
  input  logic                 Flush,
  output logic                 Busy,
  output logic                 Done,
  output logic [BIT_COUNT-1:0] Result
);

  localparam int N  = BIT_COUNT;
  localparam int CW = $clog2(N + 1);

  generate
    if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
      $error("muldiv_unit: BIT_COUNT must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [N-1:0]    a_q, b_q;
  logic [2*N-1:0]  work_q, work_d;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, neg_r_q;
  logic [N-1:0]    fin_q, result_q;

  // Operand decode for the launch cycle
  logic            a_signed, b_signed, sa, sb, is_div, is_rem, div_zero, div_ovf, fast, accept;
  logic [N-1:0]    a_mag, b_mag, fast_val;

  always_comb begin
    a_signed = (Op == OP_MULH) || (Op == OP_MULHSU) || (Op == OP_DIV) || (Op == OP_REM);
    b_signed = (Op == OP_MULH) || (Op == OP_DIV) || (Op == OP_REM);
    sa       = a_signed & OpA[N-1];
    sb       = b_signed & OpB[N-1];
    a_mag    = sa ? -OpA : OpA;
    b_mag    = sb ? -OpB : OpB;
    is_div   = Op[2];
    is_rem   = Op[1];
    div_zero = is_div && (OpB == '0);
    div_ovf  = ((Op == OP_DIV) || (Op == OP_REM)) &&
               (OpA == {1'b1, {(N-1){1'b0}}}) && (OpB == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) begin
      fast_val = is_rem ? OpA : '1;
    end else begin
      fast_val = is_rem ? '0 : OpA;
    end
    accept   = (state_q == IDLE) && Start && !Flush;
  end

  // One radix-2 step of either algorithm; work_q holds {hi, lo} of product
  // or {remainder, dividend/quotient}.
  logic [N:0]      mul_sum, div_shift;
  logic [N-1:0]    div_diff, div_rem;
  logic            div_ge;
  logic [2*N-1:0]  mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, work_q[N-1:1]};
    div_shift = {work_q[2*N-1:N], work_q[N-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[N-1:0] - b_q;
    div_rem   = div_ge ? div_diff : div_shift[N-1:0];
    div_next  = {div_rem, work_q[N-2:0], div_ge};
    work_d    = op_q[2] ? div_next : mul_next;
  end

  logic [2*N-1:0]  prod_s;
  logic [N-1:0]    quo_s, rem_s, final_val;

  always_comb begin
    prod_s = neg_q ? -work_d : work_d;
    quo_s  = neg_q ? -work_d[N-1:0] : work_d[N-1:0];
    rem_s  = neg_r_q ? -work_d[2*N-1:N] : work_d[2*N-1:N];
    case (op_q)
      OP_MUL:        final_val = prod_s[N-1:0];
      3'd1, 3'd2,
      3'd3:          final_val = prod_s[2*N-1:N];
      3'd4, 3'd5:    final_val = quo_s;
      default:       final_val = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          Busy    = 1'b1;
          state_d = fast ? DONE : CALC;
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (Flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        Done    = !Flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      fin_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= Op;
            a_q     <= a_mag;
            b_q     <= b_mag;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
            if (fast) begin
              fin_q <= fast_val;
              cnt_q <= '0;
            end else begin
              work_q <= {{N{1'b0}}, (is_div ? a_mag : b_mag)};
              cnt_q  <= CW'(N);
            end
          end
        end
        CALC: begin
          if (Flush) begin
            cnt_q <= '0;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              fin_q <= final_val;
            end
          end
        end
        DONE: begin
          if (!Flush) begin
            result_q <= fin_q;
          end
        end
        default: ;
      endcase
    end
  end

  // A flushed DONE cycle must not expose the aborted result.
  assign Result = ((state_q == DONE) && !Flush) ? fin_q : result_q;

endmodule
